// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone B4 classic initiator for the core load/store unit.
// Handles byte/half/word accesses, lane steering, alignment errors and ACK timeouts.
module wishbone_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_REQ,
    output logic                  o_READY,
    input  logic                  i_WE,
    input  logic [1:0]            i_SIZE,
    input  logic                  i_UNSIGNED,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    output logic                  o_DONE,
    output logic                  o_ERR,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic [ADDR_WIDTH-1:0] o_ADDR,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic                  o_WE,
    output logic [3:0]            o_SEL,
    output logic                  o_STB,
    input  logic                  i_ACK,
    output logic                  o_CYC,
    output logic                  o_TAGN
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t                state, state_next;
    logic [1:0]            size_q, lane_q;
    logic                  uns_q;
    logic [7:0]            cnt;

    logic                  cyc_n, stb_n, we_n, done_n, err_n, uns_n;
    logic [3:0]            sel_n;
    logic [1:0]            size_n, lane_n;
    logic [7:0]            cnt_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n, rdata_n;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~lane[0];
            2'b10:   is_aligned = (lane == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] sel_for(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   sel_for = 4'b0001 << lane;
            2'b01:   sel_for = 4'b0011 << lane;
            default: sel_for = 4'b1111;
        endcase
    endfunction

    // Store data is replicated so the slave finds it on whichever lanes SEL enables.
    function automatic logic [DATA_WIDTH-1:0] replicate(input logic [1:0] size,
                                                        input logic [DATA_WIDTH-1:0] w);
        case (size)
            2'b00:   replicate = {4{w[7:0]}};
            2'b01:   replicate = {2{w[15:0]}};
            default: replicate = w;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] steer(input logic [1:0] size, input logic uns,
                                                    input logic [1:0] lane,
                                                    input logic [DATA_WIDTH-1:0] bus);
        logic [DATA_WIDTH-1:0] s;
        s = bus >> {lane, 3'b000};
        case (size)
            2'b00:   steer = {{24{s[7] & ~uns}}, s[7:0]};
            2'b01:   steer = {{16{s[15] & ~uns}}, s[15:0]};
            default: steer = s;
        endcase
    endfunction

    assign o_READY = (state == IDLE);
    assign o_TAGN  = 1'b1;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cyc_n      = o_CYC;
        stb_n      = o_STB;
        we_n       = o_WE;
        sel_n      = o_SEL;
        addr_n     = o_ADDR;
        data_n     = o_DATA;
        rdata_n    = o_RDATA;
        done_n     = 1'b0;
        err_n      = 1'b0;
        size_n     = size_q;
        lane_n     = lane_q;
        uns_n      = uns_q;
        cnt_n      = cnt;
        case (state)
            IDLE: begin
                if (i_REQ) begin
                    if (is_aligned(i_SIZE, i_ADDR[1:0])) begin
                        addr_n     = {i_ADDR[ADDR_WIDTH-1:2], 2'b00};
                        we_n       = i_WE;
                        sel_n      = sel_for(i_SIZE, i_ADDR[1:0]);
                        data_n     = replicate(i_SIZE, i_WDATA);
                        size_n     = i_SIZE;
                        lane_n     = i_ADDR[1:0];
                        uns_n      = i_UNSIGNED;
                        cyc_n      = 1'b1;
                        stb_n      = 1'b1;
                        cnt_n      = 8'd0;
                        state_next = BUS;
                    end else begin
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        rdata_n = '0;
                    end
                end
            end
            BUS: begin
                if (i_ACK) begin
                    cyc_n      = 1'b0;
                    stb_n      = 1'b0;
                    done_n     = 1'b1;
                    rdata_n    = o_WE ? '0 : steer(size_q, uns_q, lane_q, i_DATA);
                    state_next = IDLE;
                end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    cyc_n      = 1'b0;
                    stb_n      = 1'b0;
                    done_n     = 1'b1;
                    err_n      = 1'b1;
                    rdata_n    = '0;
                    state_next = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            o_CYC   <= 1'b0;
            o_STB   <= 1'b0;
            o_WE    <= 1'b0;
            o_SEL   <= 4'b0000;
            o_ADDR  <= '0;
            o_DATA  <= '0;
            o_RDATA <= '0;
            o_DONE  <= 1'b0;
            o_ERR   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            uns_q   <= 1'b0;
            cnt     <= 8'd0;
        end else begin
            o_CYC   <= cyc_n;
            o_STB   <= stb_n;
            o_WE    <= we_n;
            o_SEL   <= sel_n;
            o_ADDR  <= addr_n;
            o_DATA  <= data_n;
            o_RDATA <= rdata_n;
            o_DONE  <= done_n;
            o_ERR   <= err_n;
            size_q  <= size_n;
            lane_q  <= lane_n;
            uns_q   <= uns_n;
            cnt     <= cnt_n;
        end
    end

endmodule
